// File: rtl/arbitro_round_robin_pkg.sv
// Shared definitions for the QoS queue scheduler.
// Holds the fixed geometry (queue count, weight width, table size), the
// derived field widths and the scheduling-mode encodings.
package arbitro_round_robin_pkg;

  localparam int QUEUE_QUANTITY    = 4;
  localparam int MAX_WEIGHT        = 64;
  localparam int TABLE_SIZE        = 8;
  localparam int TIPOS_ROUND_ROBIN = 3;

  localparam int W  = $clog2(MAX_WEIGHT);        // bits per weight
  localparam int M  = $clog2(TIPOS_ROUND_ROBIN); // bits of mode select
  localparam int QW = $clog2(QUEUE_QUANTITY);    // bits of queue index
  localparam int TW = $clog2(TABLE_SIZE);        // bits of table index

  localparam logic [QW-1:0] UNO_Q  = {{(QW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] UNO_T  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [W:0]    UNO_W1 = {{W{1'b0}}, 1'b1};

  typedef enum logic [M-1:0] {
    RR_SIMPLE   = 2'd0,
    RR_PESOS    = 2'd1,
    RR_TABLA    = 2'd2,
    RR_INVALIDO = 2'd3
  } modo_e;

endpackage

// File: rtl/arbitro_round_robin_buscador.sv
// Rotating priority finder.
// Returns the first requesting queue found scanning upward from a start
// pointer, wrapping around the queue count.
//   solicitud  : request mask, one bit per queue
//   inicio     : queue index where the scan starts
//   concesion  : granted queue index (0 when nothing is requested)
//   encontrado : high when at least one request is present
module buscador_prioridad_rotativa
  import arbitro_round_robin_pkg::*;
(
  input  logic [QUEUE_QUANTITY-1:0] solicitud,
  input  logic [QW-1:0]             inicio,
  output logic [QW-1:0]             concesion,
  output logic                      encontrado
);

  // Scan offsets from farthest to nearest so the nearest request wins;
  // the index adder wraps on its own because the queue count is a power of two.
  always_comb begin
    logic [QW-1:0] idx_s;
    idx_s      = {QW{1'b0}};
    concesion  = {QW{1'b0}};
    encontrado = 1'b0;
    for (int k = QUEUE_QUANTITY - 1; k >= 0; k--) begin
      idx_s      = inicio + QW'(k);
      concesion  = solicitud[idx_s] ? idx_s : concesion;
      encontrado = encontrado | solicitud[idx_s];
    end
  end

endmodule

// File: rtl/arbitro_round_robin.sv
// QoS queue scheduler: picks which input FIFO to pop each cycle.
// Modes: simple round robin, weighted round robin (per-queue burst length)
// and table-driven arbitration (list of queue/pop-count entries).
//   clk, rst             : clock, asynchronous active-high reset
//   enb                  : block enable (low holds all state, no pops)
//   seleccion_roundRobin : scheduling mode (3 = invalid, never pops)
//   pesos                : per-queue weights, W bits each
//   pesosArbitraje       : per-entry pop counts of the arbitration table
//   selecciones          : per-entry queue index of the arbitration table
//   fifo_empty           : empty flag per queue
//   destino_lleno        : downstream full, blocks every pop
//   pop                  : one-hot pop strobe (combinational)
//   pop_valido           : any pop this cycle
//   cola_activa          : popped queue index, 0 when nothing is popped
module arbitro_round_robin
  import arbitro_round_robin_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enb,
  input  logic [M-1:0]                 seleccion_roundRobin,
  input  logic [QUEUE_QUANTITY*W-1:0]  pesos,
  input  logic [TABLE_SIZE*W-1:0]      pesosArbitraje,
  input  logic [TABLE_SIZE*QW-1:0]     selecciones,
  input  logic [QUEUE_QUANTITY-1:0]    fifo_empty,
  input  logic                         destino_lleno,
  output logic [QUEUE_QUANTITY-1:0]    pop,
  output logic                         pop_valido,
  output logic [QW-1:0]                cola_activa
);

  logic [QW-1:0] puntero_r, puntero_nx_s;
  logic [W-1:0]  credito_r, credito_nx_s;
  logic [TW-1:0] indice_r,  indice_nx_s;
  modo_e         modo_prev_r, modo_nx_s;
  modo_e         modo_s;

  logic [W-1:0]  peso_s     [QUEUE_QUANTITY];
  logic [W-1:0]  peso_tab_s [TABLE_SIZE];
  logic [QW-1:0] sel_tab_s  [TABLE_SIZE];

  logic [QUEUE_QUANTITY-1:0] peso_no_cero_s;
  logic [QUEUE_QUANTITY-1:0] solicitud_s;
  logic [QW-1:0]             concesion_s;
  logic                      encontrado_s;
  logic                      hay_datos_s;

  logic [QUEUE_QUANTITY-1:0] pop_s;
  logic [QW-1:0]             cola_s;
  logic [W-1:0]              eff_s;
  logic [W:0]                cnt_pesos_s;
  logic [W:0]                cnt_tabla_s;
  logic [QW-1:0]             q_tab_s;
  logic [W-1:0]              w_tab_s;

  assign modo_s = modo_e'(seleccion_roundRobin);

  // Unpack the flat configuration buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      peso_s[i]         = pesos[i*W +: W];
      peso_no_cero_s[i] = (peso_s[i] != {W{1'b0}});
    end
    for (int e = 0; e < TABLE_SIZE; e++) begin
      peso_tab_s[e] = pesosArbitraje[e*W +: W];
      sel_tab_s[e]  = selecciones[e*QW +: QW];
    end
  end

  // Weighted mode ignores zero-weight queues; simple mode only needs data.
  always_comb begin
    if (modo_s == RR_PESOS) begin
      solicitud_s = ~fifo_empty & peso_no_cero_s;
    end else begin
      solicitud_s = ~fifo_empty;
    end
  end

  assign hay_datos_s = |(~fifo_empty);

  buscador_prioridad_rotativa u_buscador (
    .solicitud  (solicitud_s),
    .inicio     (puntero_r),
    .concesion  (concesion_s),
    .encontrado (encontrado_s)
  );

  // Pop decision and next-state computation for all three modes.
  always_comb begin
    puntero_nx_s = puntero_r;
    credito_nx_s = credito_r;
    indice_nx_s  = indice_r;
    modo_nx_s    = modo_prev_r;
    pop_s        = {QUEUE_QUANTITY{1'b0}};
    cola_s       = {QW{1'b0}};

    // Burst credit only carries over while staying on the same queue.
    eff_s       = (concesion_s == puntero_r) ? credito_r : {W{1'b0}};
    cnt_pesos_s = {1'b0, eff_s} + UNO_W1;
    q_tab_s     = sel_tab_s[indice_r];
    w_tab_s     = peso_tab_s[indice_r];
    cnt_tabla_s = {1'b0, credito_r} + UNO_W1;

    if (rst || !enb) begin
      puntero_nx_s = puntero_r;
    end else if (modo_s != modo_prev_r) begin
      // A mode change restarts scheduling from a clean state, even when
      // the destination is full.
      puntero_nx_s = {QW{1'b0}};
      credito_nx_s = {W{1'b0}};
      indice_nx_s  = {TW{1'b0}};
      modo_nx_s    = modo_s;
    end else if (destino_lleno || !hay_datos_s) begin
      puntero_nx_s = puntero_r;
    end else begin
      case (modo_s)
        RR_SIMPLE: begin
          if (encontrado_s) begin
            pop_s[concesion_s] = 1'b1;
            cola_s             = concesion_s;
            puntero_nx_s       = concesion_s + UNO_Q;
          end else begin
            puntero_nx_s = puntero_r;
          end
        end
        RR_PESOS: begin
          if (encontrado_s) begin
            pop_s[concesion_s] = 1'b1;
            cola_s             = concesion_s;
            // >= keeps a weight lowered mid-burst from stalling the queue.
            if (cnt_pesos_s >= {1'b0, peso_s[concesion_s]}) begin
              puntero_nx_s = concesion_s + UNO_Q;
              credito_nx_s = {W{1'b0}};
            end else begin
              puntero_nx_s = concesion_s;
              credito_nx_s = cnt_pesos_s[W-1:0];
            end
          end else begin
            puntero_nx_s = puntero_r;
          end
        end
        RR_TABLA: begin
          if (fifo_empty[q_tab_s] || (w_tab_s == {W{1'b0}})) begin
            // Unusable entry: skip one entry per cycle without popping.
            indice_nx_s  = indice_r + UNO_T;
            credito_nx_s = {W{1'b0}};
          end else begin
            pop_s[q_tab_s] = 1'b1;
            cola_s         = q_tab_s;
            if (cnt_tabla_s >= {1'b0, w_tab_s}) begin
              indice_nx_s  = indice_r + UNO_T;
              credito_nx_s = {W{1'b0}};
            end else begin
              credito_nx_s = cnt_tabla_s[W-1:0];
            end
          end
        end
        default: begin
          puntero_nx_s = puntero_r;
        end
      endcase
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      puntero_r   <= {QW{1'b0}};
      credito_r   <= {W{1'b0}};
      indice_r    <= {TW{1'b0}};
      modo_prev_r <= RR_SIMPLE;
    end else begin
      puntero_r   <= puntero_nx_s;
      credito_r   <= credito_nx_s;
      indice_r    <= indice_nx_s;
      modo_prev_r <= modo_nx_s;
    end
  end

  assign pop         = pop_s;
  assign pop_valido  = |pop_s;
  assign cola_activa = cola_s;

endmodule

// File: tb/tb_arbitro_round_robin.sv
// Self-checking bench for arbitro_round_robin: a behavioural reference model
// pushes the expected pop/cola per cycle into a scoreboard queue, which is
// popped and compared against the DUT outputs; test-plan sequences are also
// checked against literal queue orders.
module tb_arbitro_round_robin;

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [1:0]  seleccion_roundRobin;
  logic [23:0] pesos;
  logic [47:0] pesosArbitraje;
  logic [15:0] selecciones;
  logic [3:0]  fifo_empty;
  logic        destino_lleno;
  logic [3:0]  pop;
  logic        pop_valido;
  logic [1:0]  cola_activa;

  arbitro_round_robin dut (
    .clk                  (clk),
    .rst                  (rst),
    .enb                  (enb),
    .seleccion_roundRobin (seleccion_roundRobin),
    .pesos                (pesos),
    .pesosArbitraje       (pesosArbitraje),
    .selecciones          (selecciones),
    .fifo_empty           (fifo_empty),
    .destino_lleno        (destino_lleno),
    .pop                  (pop),
    .pop_valido           (pop_valido),
    .cola_activa          (cola_activa)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] e_pop;
    logic       e_valido;
    logic [1:0] e_cola;
  } esperado_t;

  esperado_t sb_q[$];

  int vectores    = 0;
  int miscompares = 0;

  // configuration seen by the model
  int wq    [4];
  int tab_q [8];
  int tab_w [8];

  // model state and its next value
  int m_ptr, m_cred, m_idx, m_modo;
  int n_ptr, n_cred, n_idx, n_modo;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectores++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cargar_config();
    for (int i = 0; i < 4; i++) pesos[i*6 +: 6] = 6'(wq[i]);
    for (int e = 0; e < 8; e++) begin
      pesosArbitraje[e*6 +: 6] = 6'(tab_w[e]);
      selecciones[e*2 +: 2]    = 2'(tab_q[e]);
    end
  endtask

  task automatic reset_modelo();
    m_ptr = 0; m_cred = 0; m_idx = 0; m_modo = 0;
  endtask

  // Reference behaviour for one cycle, from current inputs and model state.
  task automatic model_eval(output logic [3:0] e_pop);
    bit found;
    int g, eff, q, w, cand;
    e_pop = 4'b0000;
    n_ptr = m_ptr; n_cred = m_cred; n_idx = m_idx; n_modo = m_modo;
    found = 1'b0; g = 0;
    if (rst === 1'b1 || enb === 1'b0) begin
      g = 0;
    end else if (int'(seleccion_roundRobin) != m_modo) begin
      n_ptr = 0; n_cred = 0; n_idx = 0; n_modo = int'(seleccion_roundRobin);
    end else if (destino_lleno || fifo_empty == 4'hF || seleccion_roundRobin == 2'd3) begin
      g = 0;
    end else if (seleccion_roundRobin == 2'd2) begin
      q = tab_q[m_idx];
      w = tab_w[m_idx];
      if (fifo_empty[q] || w == 0) begin
        n_idx = (m_idx + 1) % 8; n_cred = 0;
      end else begin
        e_pop[q] = 1'b1;
        if (m_cred + 1 >= w) begin n_idx = (m_idx + 1) % 8; n_cred = 0; end
        else n_cred = m_cred + 1;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        cand = (m_ptr + k) % 4;
        if (!found && !fifo_empty[cand] && (seleccion_roundRobin == 2'd0 || wq[cand] != 0)) begin
          found = 1'b1; g = cand;
        end
      end
      if (found) begin
        e_pop[g] = 1'b1;
        if (seleccion_roundRobin == 2'd0) begin
          n_ptr = (g + 1) % 4;
        end else begin
          eff = (g == m_ptr) ? m_cred : 0;
          if (eff + 1 >= wq[g]) begin n_ptr = (g + 1) % 4; n_cred = 0; end
          else begin n_ptr = g; n_cred = eff + 1; end
        end
      end
    end
  endtask

  task automatic evaluar_y_comparar(input int plan);
    esperado_t x, r;
    model_eval(x.e_pop);
    x.e_valido = |x.e_pop;
    x.e_cola   = 2'd0;
    for (int i = 0; i < 4; i++) if (x.e_pop[i]) x.e_cola = 2'(i);
    sb_q.push_back(x);
    r = sb_q.pop_front();
    comprobar("pop", 32'(pop), 32'(r.e_pop));
    comprobar("pop_valido", 32'(pop_valido), 32'(r.e_valido));
    comprobar("cola_activa", 32'(cola_activa), 32'(r.e_cola));
    if (plan != -2) comprobar("plan_pop", 32'(pop), (plan < 0) ? 32'd0 : (32'd1 << plan));
  endtask

  // One clock cycle: drive at negedge, compare, optional async reset pulse,
  // advance the model at posedge. Returns at posedge+1.
  task automatic step(input logic [1:0] m, input logic [3:0] f, input logic d,
                      input logic e, input int plan, input bit pulso);
    @(negedge clk);
    seleccion_roundRobin = m;
    fifo_empty           = f;
    destino_lleno        = d;
    enb                  = e;
    #1;
    evaluar_y_comparar(plan);
    if (pulso) begin
      #1 rst = 1'b1;
      #1;
      reset_modelo();
      evaluar_y_comparar(-1);
      rst = 1'b0;
      #1;
      evaluar_y_comparar(-2);
    end
    @(posedge clk);
    m_ptr = n_ptr; m_cred = n_cred; m_idx = n_idx; m_modo = n_modo;
    #1;
  endtask

  initial begin
    rst = 1'b1; enb = 1'b1; seleccion_roundRobin = 2'd0;
    fifo_empty = 4'hF; destino_lleno = 1'b0;
    for (int i = 0; i < 4; i++) wq[i] = 0;
    for (int e = 0; e < 8; e++) begin tab_q[e] = 0; tab_w[e] = 0; end
    cargar_config();
    fifo_empty = 4'h0;
    reset_modelo();
    #3;
    comprobar("reset_pop", 32'(pop), 32'd0);
    comprobar("reset_pop_valido", 32'(pop_valido), 32'd0);
    comprobar("reset_cola", 32'(cola_activa), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // simple round robin over four busy queues
    step(2'd0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 2, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 3, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd0, 4'hF, 1'b0, 1'b1, -1, 1'b0);
    step(2'd0, 4'b1011, 1'b0, 1'b1, 2, 1'b0);
    step(2'd0, 4'b1110, 1'b0, 1'b1, 0, 1'b0);

    // weighted round robin, q2 has zero weight
    wq[0] = 2; wq[1] = 3; wq[2] = 0; wq[3] = 1;
    cargar_config();
    step(2'd1, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 3, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);

    // destination full mid-burst holds the credit
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b1, 1'b1, -1, 1'b0);
    step(2'd1, 4'h0, 1'b1, 1'b1, -1, 1'b0);
    step(2'd1, 4'h0, 1'b1, 1'b1, -1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 3, 1'b0);

    // switch to simple mode in the middle of a q1 burst
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 1, 1'b0);

    // weight lowered mid-burst must not stall the queue
    wq[0] = 3; wq[1] = 1; wq[2] = 1; wq[3] = 1;
    cargar_config();
    step(2'd1, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    wq[0] = 1;
    cargar_config();
    step(2'd1, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    step(2'd1, 4'h0, 1'b0, 1'b1, 1, 1'b0);

    // table mode: entry0=(q2,2), entry1=(q0,1), the rest unusable
    tab_q[0] = 2; tab_w[0] = 2;
    tab_q[1] = 0; tab_w[1] = 1;
    cargar_config();
    step(2'd2, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd2, 4'h0, 1'b0, 1'b1, 2, 1'b0);
    step(2'd2, 4'h0, 1'b0, 1'b1, 2, 1'b0);
    step(2'd2, 4'h0, 1'b0, 1'b1, 0, 1'b0);
    for (int k = 0; k < 6; k++) step(2'd2, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd2, 4'h0, 1'b0, 1'b1, 2, 1'b0);
    step(2'd2, 4'hF, 1'b0, 1'b1, -1, 1'b0);
    step(2'd2, 4'h0, 1'b0, 1'b1, 2, 1'b0);

    // async reset at indice=1 while q0 is being popped
    step(2'd2, 4'h0, 1'b0, 1'b1, 0, 1'b1);
    step(2'd2, 4'h0, 1'b0, 1'b1, 2, 1'b0);

    // invalid mode never pops; enable low blocks mode change
    step(2'd3, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd3, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b0, -1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, -1, 1'b0);
    step(2'd0, 4'h0, 1'b0, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectores, miscompares);
    $finish;
  end

endmodule
